pulsed_decoder_3_8: RTL
=======================

// Module: pulsed_decoder_3_8
// PURPOSE
//  Registered 3-to-8 decoder: the receive-side counterpart of the 8-3 priority encoder.
//  - Accepts a 3-bit encoded index through a valid/ready handshake.
//  - Drives the matching one-hot line for exactly PULSE_CYCLES clocks.
//  - Then holds all lines low for GAP_CYCLES clocks before the next index is shown.
//  - Counts accepted transactions. Sits after an encoder/link to re-expand requests to 8 strobes.
// PARAMETERS
//  PULSE_CYCLES  4  clocks each one-hot output is held high; legal range 1..255
//  GAP_CYCLES    1  clocks of all-zero output after each pulse; legal range 0..255
//  COUNT_WIDTH   8  width of the accepted-transaction counter
// PORTS
//  Clock_In            input   1            single clock; all state changes on its rising edge
//  Reset_In            input   1            asynchronous, active-low reset
//  Encoded_Value_In    input   3            index to decode (0..7)
//  Valid_In            input   1            Encoded_Value_In is valid this cycle
//  Ready_Out           output  1            block accepts Encoded_Value_In this cycle
//  Abort_In            input   1            synchronous abort of the current pulse/gap
//  Data_Out            output  8            registered one-hot output; bit n = index n
//  Busy_Out            output  1            high in PULSE or GAP
//  Accepted_Count_Out  output  COUNT_WIDTH  number of accepted transactions; wraps
// BEHAVIOUR
//  - Reset (Reset_In=0, immediate, no clock needed):
//    Data_Out=0, state=IDLE, phase counter=0, Accepted_Count_Out=0, Busy_Out=0.
//    Ready_Out=1 once Reset_In=1.
//  - FSM states: IDLE, PULSE, GAP. Phase counter is 8 bits.
//  - Ready_Out is combinational from state and counter only, never from Valid_In.
//    It is high in IDLE, and on the last cycle of the final phase:
//    GAP with counter==0, or PULSE with counter==0 when GAP_CYCLES==0.
//  - Accept = Valid_In & Ready_Out & ~Abort_In at a rising edge. On accept:
//    Data_Out <= 1<<Encoded_Value_In; state <= PULSE; counter <= PULSE_CYCLES-1; count += 1.
//  - Latency: Data_Out shows the one-hot value on the cycle after the accept edge.
//  - PULSE: at each edge, if counter!=0 then decrement. If counter==0:
//    - GAP_CYCLES>0: Data_Out <= 0; state <= GAP; counter <= GAP_CYCLES-1.
//    - GAP_CYCLES==0: accept if offered (new one-hot follows with no zero cycle),
//      else Data_Out <= 0 and state <= IDLE.
//  - GAP: Data_Out=0. At each edge, if counter!=0 then decrement.
//    If counter==0: accept if offered, else state <= IDLE.
//  - Throughput: one transaction per PULSE_CYCLES+GAP_CYCLES clocks with Valid_In held high.
//  - Abort_In=1 at an edge, from any state: Data_Out <= 0; state <= IDLE; counter <= 0.
//    Abort has priority over a simultaneous Valid_In: nothing is accepted and the count is unchanged.
//  - Accepted_Count_Out wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
//  - Encoded_Value_In is sampled only on accept; changes mid-pulse do not affect Data_Out.
//  - Invariant: Data_Out is always 0 or exactly one-hot. Busy_Out = (state != IDLE).
// TESTING (defaults PULSE_CYCLES=4, GAP_CYCLES=1)
//  1 Reset: hold Reset_In=0 with random inputs.
//    -> Data_Out=8'h00, Busy_Out=0, count=0; Ready_Out=1 after release.
//  2 Single: Valid_In=1 for 1 cycle, index=5.
//    -> Data_Out=8'h20 for exactly 4 cycles, then 8'h00.
//    -> Ready_Out low for the 4 pulse cycles, high in the gap cycle; count=1.
//  3 Back-to-back: Valid_In held high, index 0 then 7.
//    -> Data_Out=01,01,01,01,00,80,80,80,80,00; count=2.
//    -> Repeat with GAP_CYCLES=0: 01 x4 then 80 x4, no zero cycle between.
//  4 Abort: assert Abort_In with Valid_In=1 in the 2nd pulse cycle of index 3.
//    -> Data_Out=0 on the next cycle; state IDLE; count unchanged; no new pulse.
//  5 Reset mid-operation: drop Reset_In during a pulse of index 6.
//    -> Data_Out=0 before the next clock edge; normal operation after release.
//  6 Round trip and wrap: 256 random accepts through the 8-3 priority encoder.
//    -> Each decoded pulse equals the highest set input; count wraps to 0.

Source files
------------

// File: rtl/pulsed_decoder_3_8.sv
// Registered 3-to-8 pulsed decoder.
// Accepts a 3-bit index over valid/ready, drives the matching one-hot line
// for PULSE_CYCLES clocks, then all-zero for GAP_CYCLES clocks, and counts
// accepted transactions (wrapping counter).
module pulsed_decoder_3_8 #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned COUNT_WIDTH  = 8
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic [2:0]             Encoded_Value_In,
    input  logic                   Valid_In,
    output logic                   Ready_Out,
    input  logic                   Abort_In,
    output logic [7:0]             Data_Out,
    output logic                   Busy_Out,
    output logic [COUNT_WIDTH-1:0] Accepted_Count_Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam bit         HAS_GAP    = (GAP_CYCLES != 0);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             data_q, data_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic last_phase;
    logic accept;

    // Ready depends only on state and phase counter: idle, or the final
    // cycle of the last phase (gap, or pulse when there is no gap).
    always_comb begin
        last_phase = 1'b0;
        if (cnt_q == '0) begin
            if (state_q == GAP) begin
                last_phase = 1'b1;
            end else if (state_q == PULSE && !HAS_GAP) begin
                last_phase = 1'b1;
            end
        end
        Ready_Out = (state_q == IDLE) || last_phase;
        accept    = Valid_In && Ready_Out && !Abort_In;
    end

    // Next-state logic: abort wins, then accept, then phase sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        if (Abort_In) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
        end else if (accept) begin
            state_d = PULSE;
            cnt_d   = PULSE_LOAD;
            data_d  = 8'(1) << Encoded_Value_In;
            count_d = count_q + COUNT_WIDTH'(1);
        end else begin
            unique case (state_q)
                PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (HAS_GAP) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                        data_d  = '0;
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                    end
                end
                GAP: begin
                    data_d = '0;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    data_d = '0;
                end
            endcase
        end
    end

    // State, counter, output and transaction-count registers.
    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign Data_Out           = data_q;
    assign Busy_Out           = (state_q != IDLE);
    assign Accepted_Count_Out = count_q;

endmodule
